dit_miter_monitor: RTL and testbench

Parametrised successor to the two-copy AES miter. It observes NUM_CH identical-design instances driven with the same non-secret inputs, and checks data-independent timing cycle by cycle. It compares each instance's control-observable vector against channel 0, measures per-transaction latency, and raises sticky divergence and timeout flags. Formal properties and simulation benches bind to these flags. It sits beside the instances in the miter top and has no effect on them.

---
 rtl/dit_miter_monitor.sv | 213 +++++++++++++++++++++
 tb/tb_dit_miter_monitor.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dit_miter_monitor.sv
// Data-independent-timing miter monitor.
// Observes NUM_CH copies of one design driven with identical public inputs.
// Channel 0 is the reference. Each armed cycle, the per-channel control
// vectors are compared against channel 0. Per-transaction latencies are
// compared once every channel has finished its transaction. Mismatches and
// hung channels raise sticky flags that hold until rst or clear. The monitor
// only observes the instances and never drives them.
module dit_miter_monitor #(
    parameter int NUM_CH  = 2,
    parameter int CTRL_W  = 4,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     arm,
    input  logic                     clear,
    input  logic [NUM_CH-1:0]        start,
    input  logic [NUM_CH-1:0]        done,
    input  logic [NUM_CH*CTRL_W-1:0] ctrl,
    output logic [NUM_CH-1:0]        busy,
    output logic [NUM_CH*CNT_W-1:0]  lat_out,
    output logic                     ctrl_div,
    output logic                     lat_div,
    output logic [NUM_CH-1:0]        div_mask,
    output logic [CNT_W-1:0]         div_cycle,
    output logic                     timeout,
    output logic                     any_div
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_PEND = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE      = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

    // Counter increment that sticks at the all-ones value instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == CNT_MAX) begin
            return v;
        end else begin
            return v + CNT_ONE;
        end
    endfunction

    state_t           state_q [NUM_CH];
    state_t           state_d [NUM_CH];
    logic [CNT_W-1:0] cnt_q   [NUM_CH];
    logic [CNT_W-1:0] cnt_d   [NUM_CH];
    logic [CNT_W-1:0] lat_q   [NUM_CH];
    logic [CNT_W-1:0] lat_d   [NUM_CH];

    logic [NUM_CH-1:0] busy_q, busy_d;
    logic              ctrl_div_q, ctrl_div_d;
    logic              lat_div_q, lat_div_d;
    logic [NUM_CH-1:0] div_mask_q, div_mask_d;
    logic [CNT_W-1:0]  div_cycle_q, div_cycle_d;
    logic              timeout_q, timeout_d;
    logic [CNT_W-1:0]  cyc_q, cyc_d;

    logic              all_pend_s;
    logic              lat_hit_s;
    logic              ctrl_hit_s;
    logic              to_hit_s;
    logic [NUM_CH-1:0] lat_mask_s;
    logic [NUM_CH-1:0] ctrl_mask_s;

    // Next-state logic: per-channel FSMs, compare points and sticky status.
    always_comb begin
        all_pend_s  = 1'b1;
        lat_hit_s   = 1'b0;
        ctrl_hit_s  = 1'b0;
        to_hit_s    = 1'b0;
        lat_mask_s  = '0;
        ctrl_mask_s = '0;

        for (int c = 0; c < NUM_CH; c++) begin
            all_pend_s = all_pend_s & (state_q[c] == ST_PEND);
        end

        // Channel 0 is the reference, so only channels 1.. can be flagged.
        for (int c = 1; c < NUM_CH; c++) begin
            if (all_pend_s && (lat_q[c] != lat_q[0])) begin
                lat_hit_s     = 1'b1;
                lat_mask_s[c] = 1'b1;
            end else begin
                lat_mask_s[c] = 1'b0;
            end
            if (arm && (ctrl[c*CTRL_W +: CTRL_W] != ctrl[CTRL_W-1:0])) begin
                ctrl_hit_s     = 1'b1;
                ctrl_mask_s[c] = 1'b1;
            end else begin
                ctrl_mask_s[c] = 1'b0;
            end
        end

        for (int c = 0; c < NUM_CH; c++) begin
            state_d[c] = state_q[c];
            cnt_d[c]   = cnt_q[c];
            lat_d[c]   = lat_q[c];
            case (state_q[c])
                ST_IDLE: begin
                    // A done seen while idle belongs to no transaction.
                    if (start[c]) begin
                        state_d[c] = ST_BUSY;
                        cnt_d[c]   = '0;
                    end else begin
                        state_d[c] = ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    cnt_d[c] = sat_inc(cnt_q[c]);
                    if (done[c]) begin
                        state_d[c] = ST_PEND;
                        lat_d[c]   = sat_inc(cnt_q[c]);
                    end else if (cnt_q[c] == TIMEOUT_LAST) begin
                        to_hit_s = 1'b1;
                    end else begin
                        state_d[c] = ST_BUSY;
                    end
                end
                ST_PEND: begin
                    // Wait for every channel so latencies are compared together.
                    if (all_pend_s) begin
                        state_d[c] = ST_IDLE;
                    end else begin
                        state_d[c] = ST_PEND;
                    end
                end
                default: begin
                    state_d[c] = ST_IDLE;
                end
            endcase
            busy_d[c] = (state_d[c] == ST_BUSY);
        end

        if (clear) begin
            ctrl_div_d  = 1'b0;
            lat_div_d   = 1'b0;
            div_mask_d  = '0;
            div_cycle_d = '0;
            timeout_d   = 1'b0;
            cyc_d       = '0;
        end else begin
            ctrl_div_d = ctrl_div_q | ctrl_hit_s;
            lat_div_d  = lat_div_q | lat_hit_s;
            div_mask_d = div_mask_q | ctrl_mask_s | lat_mask_s;
            timeout_d  = timeout_q | to_hit_s;
            if (ctrl_hit_s && !ctrl_div_q) begin
                div_cycle_d = cyc_q;
            end else begin
                div_cycle_d = div_cycle_q;
            end
            if (arm) begin
                cyc_d = sat_inc(cyc_q);
            end else begin
                cyc_d = cyc_q;
            end
        end
    end

    // State registers; rst aborts every transaction and drops captured latencies.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                state_q[c] <= ST_IDLE;
                cnt_q[c]   <= '0;
                lat_q[c]   <= '0;
            end
            busy_q      <= '0;
            ctrl_div_q  <= 1'b0;
            lat_div_q   <= 1'b0;
            div_mask_q  <= '0;
            div_cycle_q <= '0;
            timeout_q   <= 1'b0;
            cyc_q       <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                state_q[c] <= state_d[c];
                cnt_q[c]   <= cnt_d[c];
                lat_q[c]   <= lat_d[c];
            end
            busy_q      <= busy_d;
            ctrl_div_q  <= ctrl_div_d;
            lat_div_q   <= lat_div_d;
            div_mask_q  <= div_mask_d;
            div_cycle_q <= div_cycle_d;
            timeout_q   <= timeout_d;
            cyc_q       <= cyc_d;
        end
    end

    // Pack the per-channel latency registers onto the flat output bus.
    always_comb begin
        lat_out = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            lat_out[c*CNT_W +: CNT_W] = lat_q[c];
        end
    end

    assign busy      = busy_q;
    assign ctrl_div  = ctrl_div_q;
    assign lat_div   = lat_div_q;
    assign div_mask  = div_mask_q;
    assign div_cycle = div_cycle_q;
    assign timeout   = timeout_q;
    assign any_div   = ctrl_div_q | lat_div_q | timeout_q;

endmodule

// File: tb/tb_dit_miter_monitor.sv
// Bench for dit_miter_monitor: directed scenarios on a 2-channel and a
// 4-channel instance, plus random traffic on the 2-channel instance checked
// against a transaction-level model (start time / done time subtraction).
module tb_dit_miter_monitor;

    localparam int TO = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        clear = 1'b0;

    logic        arm2 = 1'b0;
    logic [1:0]  start2 = 2'b00, done2 = 2'b00;
    logic [7:0]  ctrl2 = 8'h00;
    logic [1:0]  busy2, mask2;
    logic [31:0] lat2;
    logic [15:0] dcyc2;
    logic        cdiv2, ldiv2, to2, any2;

    logic        arm4 = 1'b0;
    logic [3:0]  start4 = 4'h0, done4 = 4'h0;
    logic [15:0] ctrl4 = 16'h0000;
    logic [3:0]  busy4, mask4;
    logic [63:0] lat4;
    logic [15:0] dcyc4;
    logic        cdiv4, ldiv4, to4, any4;

    int n_checks = 0;
    int n_pass   = 0;

    dit_miter_monitor #(.NUM_CH(2), .CTRL_W(4), .CNT_W(16), .TIMEOUT(TO)) dut2 (
        .clk(clk), .rst(rst), .arm(arm2), .clear(clear), .start(start2), .done(done2),
        .ctrl(ctrl2), .busy(busy2), .lat_out(lat2), .ctrl_div(cdiv2), .lat_div(ldiv2),
        .div_mask(mask2), .div_cycle(dcyc2), .timeout(to2), .any_div(any2));

    dit_miter_monitor #(.NUM_CH(4), .CTRL_W(4), .CNT_W(16), .TIMEOUT(TO)) dut4 (
        .clk(clk), .rst(rst), .arm(arm4), .clear(clear), .start(start4), .done(done4),
        .ctrl(ctrl4), .busy(busy4), .lat_out(lat4), .ctrl_div(cdiv4), .lat_div(ldiv4),
        .div_mask(mask4), .div_cycle(dcyc4), .timeout(to4), .any_div(any4));

    // Transaction-level reference for the 2-channel instance.
    int          now = 0;
    bit          m_act [2];
    bit          m_pend [2];
    int          m_start [2];
    logic [15:0] m_lat [2];
    logic        m_cdiv, m_ldiv, m_to;
    logic [1:0]  m_mask;
    logic [15:0] m_dcyc;
    int          m_cyc;

    task automatic model_step();
        bit allp, lat_hit, ctrl_hit, to_hit;
        if (rst) begin
            for (int c = 0; c < 2; c++) begin
                m_act[c] = 0; m_pend[c] = 0; m_start[c] = 0; m_lat[c] = 16'd0;
            end
            m_cdiv = 1'b0; m_ldiv = 1'b0; m_to = 1'b0; m_mask = 2'b00;
            m_dcyc = 16'd0; m_cyc = 0;
        end else begin
            allp     = m_pend[0] && m_pend[1];
            lat_hit  = allp && (m_lat[1] != m_lat[0]);
            ctrl_hit = arm2 && (ctrl2[7:4] != ctrl2[3:0]);
            to_hit   = 0;
            for (int c = 0; c < 2; c++) begin
                if (m_pend[c]) begin
                    if (allp) m_pend[c] = 0;
                end else if (m_act[c]) begin
                    if (done2[c]) begin
                        m_act[c] = 0; m_pend[c] = 1;
                        m_lat[c] = 16'(now - m_start[c]);
                    end else if (now - m_start[c] == TO) begin
                        to_hit = 1;
                    end
                end else if (start2[c]) begin
                    m_act[c] = 1; m_start[c] = now;
                end
            end
            if (clear) begin
                m_cdiv = 1'b0; m_ldiv = 1'b0; m_to = 1'b0; m_mask = 2'b00;
                m_dcyc = 16'd0; m_cyc = 0;
            end else begin
                if (lat_hit) begin m_ldiv = 1'b1; m_mask[1] = 1'b1; end
                if (ctrl_hit) begin
                    if (!m_cdiv) m_dcyc = 16'(m_cyc);
                    m_cdiv = 1'b1; m_mask[1] = 1'b1;
                end
                if (to_hit) m_to = 1'b1;
                if (arm2 && m_cyc < 65535) m_cyc++;
            end
        end
        now++;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        arm2 = 1'b0; start2 = 2'b00; done2 = 2'b00; ctrl2 = 8'h00;
        arm4 = 1'b0; start4 = 4'h0; done4 = 4'h0; ctrl4 = 16'h0000;
        clear = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({busy2, lat2, cdiv2, ldiv2, mask2, dcyc2, to2, any2} !== 56'd0) begin
            $display("FAIL reset2 got busy=%b lat=%h flags=%b%b%b%b mask=%b dcyc=%0d want all 0",
                     busy2, lat2, cdiv2, ldiv2, to2, any2, mask2, dcyc2);
        end else n_pass++;
        n_checks++;
        if ({busy4, lat4, cdiv4, ldiv4, mask4, dcyc4, to4, any4} !== 92'd0) begin
            $display("FAIL reset4 got busy=%b lat=%h mask=%b want all 0", busy4, lat4, mask4);
        end else n_pass++;
    endtask

    task automatic test_equal_timing();
        logic [1:0] exp_busy;
        do_reset();
        for (int k = 0; k < 24; k++) begin
            exp_busy = (k >= 6 && k <= 18) ? 2'b11 : 2'b00;
            n_checks++;
            if (busy2 !== exp_busy || any2 !== 1'b0) begin
                $display("FAIL eq_busy k=%0d got busy=%b any=%b want busy=%b any=0", k, busy2, any2, exp_busy);
            end else n_pass++;
            if (k == 19) begin
                n_checks++;
                if (lat2 !== {16'd13, 16'd13}) $display("FAIL eq_lat got %h want %h", lat2, {16'd13, 16'd13});
                else n_pass++;
            end
            arm2 = 1'b1;
            start2 = (k == 5) ? 2'b11 : 2'b00;
            done2 = (k == 18) ? 2'b11 : 2'b00;
            ctrl2[3:0] = 4'($urandom);
            ctrl2[7:4] = ctrl2[3:0];
            tick();
        end
    endtask

    task automatic test_latency_skew();
        do_reset();
        for (int k = 0; k < 24; k++) begin
            if (k == 20) begin
                n_checks++;
                if (lat2 !== {16'd14, 16'd13} || ldiv2 !== 1'b0)
                    $display("FAIL skew_lat got lat=%h ldiv=%b want %h ldiv=0", lat2, ldiv2, {16'd14, 16'd13});
                else n_pass++;
            end
            if (k == 21) begin
                n_checks++;
                if (ldiv2 !== 1'b1 || mask2 !== 2'b10 || any2 !== 1'b1 || busy2 !== 2'b00)
                    $display("FAIL skew_div got ldiv=%b mask=%b any=%b busy=%b want 1 10 1 00",
                             ldiv2, mask2, any2, busy2);
                else n_pass++;
            end
            arm2 = 1'b1;
            start2 = (k == 5) ? 2'b11 : 2'b00;
            done2 = {(k == 19), (k == 18)};
            ctrl2 = 8'h55;
            tick();
        end
    endtask

    task automatic test_ctrl_divergence();
        do_reset();
        for (int k = 0; k < 16; k++) begin
            if (k >= 1 && k <= 13) begin
                n_checks++;
                if (cdiv2 !== (k >= 8) || (k >= 8 && (dcyc2 !== 16'd7 || mask2 !== 2'b10)))
                    $display("FAIL ctrl_div k=%0d got cdiv=%b dcyc=%0d mask=%b want cdiv=%b dcyc=7",
                             k, cdiv2, dcyc2, mask2, (k >= 8));
                else n_pass++;
            end
            if (k == 14) begin
                n_checks++;
                if (cdiv2 !== 1'b0 || dcyc2 !== 16'd0 || mask2 !== 2'b00)
                    $display("FAIL ctrl_clear got cdiv=%b dcyc=%0d mask=%b want 0 0 00", cdiv2, dcyc2, mask2);
                else n_pass++;
            end
            arm2 = 1'b1;
            clear = (k == 13);
            ctrl2[3:0] = 4'($urandom);
            ctrl2[7:4] = (k == 7) ? (ctrl2[3:0] ^ 4'h1) : ctrl2[3:0];
            tick();
        end
        clear = 1'b0;
    endtask

    task automatic test_timeout();
        do_reset();
        for (int k = 0; k < 22; k++) begin
            if (k >= 1) begin
                n_checks++;
                if (busy2 !== 2'b11 || to2 !== (k >= 17))
                    $display("FAIL timeout k=%0d got busy=%b to=%b want busy=11 to=%b", k, busy2, to2, (k >= 17));
                else n_pass++;
            end
            start2 = (k == 0) ? 2'b11 : 2'b00;
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if (busy2 !== 2'b00 || to2 !== 1'b0 || any2 !== 1'b0)
            $display("FAIL timeout_rst got busy=%b to=%b any=%b want 00 0 0", busy2, to2, any2);
        else n_pass++;
    endtask

    task automatic test_edge_cases();
        do_reset();
        start2 = 2'b11; done2 = 2'b11; tick();
        n_checks++;
        if (busy2 !== 2'b11) $display("FAIL edge_start_done got busy=%b want 11", busy2);
        else n_pass++;
        start2 = 2'b00; done2 = 2'b11; tick();
        n_checks++;
        if (busy2 !== 2'b00 || lat2 !== {16'd1, 16'd1}) $display("FAIL edge_lat1 got busy=%b lat=%h want 00 00010001", busy2, lat2);
        else n_pass++;
        done2 = 2'b00; tick();
        // cycle 3..: start both, ch0 done at 5, start ch0 while PEND at 6, ch1 done at 7
        for (int k = 3; k < 12; k++) begin
            if (k == 7) begin
                n_checks++;
                if (busy2 !== 2'b10) $display("FAIL edge_pend_start got busy=%b want 10", busy2);
                else n_pass++;
            end
            if (k == 9 || k == 11) begin
                n_checks++;
                if (busy2 !== 2'b00 || lat2 !== {16'd4, 16'd2} || ldiv2 !== 1'b1 || mask2 !== 2'b10)
                    $display("FAIL edge_return k=%0d got busy=%b lat=%h ldiv=%b mask=%b want 00 00040002 1 10",
                             k, busy2, lat2, ldiv2, mask2);
                else n_pass++;
            end
            start2 = (k == 3) ? 2'b11 : ((k == 6) ? 2'b01 : 2'b00);
            done2  = (k == 5) ? 2'b01 : ((k == 7) ? 2'b10 : ((k == 10) ? 2'b11 : 2'b00));
            tick();
        end
        start2 = 2'b00; done2 = 2'b00;
    endtask

    task automatic test_channel_scaling();
        do_reset();
        for (int k = 0; k < 12; k++) begin
            if (k == 4) begin
                n_checks++;
                if (cdiv4 !== 1'b1 || mask4 !== 4'b1000 || dcyc4 !== 16'd3)
                    $display("FAIL scale_ctrl got cdiv=%b mask=%b dcyc=%0d want 1 1000 3", cdiv4, mask4, dcyc4);
                else n_pass++;
            end
            if (k == 9) begin
                n_checks++;
                if (ldiv4 !== 1'b0) $display("FAIL scale_early got ldiv=%b want 0", ldiv4);
                else n_pass++;
            end
            if (k == 10) begin
                n_checks++;
                if (ldiv4 !== 1'b1 || mask4 !== 4'b1100 || cdiv4 !== 1'b1 ||
                    lat4 !== {16'd5, 16'd7, 16'd5, 16'd5} || busy4 !== 4'h0)
                    $display("FAIL scale_lat got ldiv=%b mask=%b cdiv=%b lat=%h busy=%b want 1 1100 1 0005000700050005 0000",
                             ldiv4, mask4, cdiv4, lat4, busy4);
                else n_pass++;
            end
            arm4 = 1'b1;
            start4 = (k == 1) ? 4'hF : 4'h0;
            done4 = (k == 6) ? 4'b1011 : ((k == 8) ? 4'b0100 : 4'h0);
            ctrl4[3:0] = 4'($urandom);
            ctrl4[7:4] = ctrl4[3:0];
            ctrl4[11:8] = ctrl4[3:0];
            ctrl4[15:12] = (k == 3) ? ~ctrl4[3:0] : ctrl4[3:0];
            tick();
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 600; k++) begin
            n_checks++;
            if (busy2 !== {m_act[1], m_act[0]} || lat2 !== {m_lat[1], m_lat[0]} ||
                cdiv2 !== m_cdiv || ldiv2 !== m_ldiv || mask2 !== m_mask ||
                dcyc2 !== m_dcyc || to2 !== m_to || any2 !== (m_cdiv | m_ldiv | m_to)) begin
                $display("FAIL rand k=%0d got busy=%b lat=%h c=%b l=%b m=%b d=%0d t=%b a=%b want busy=%b lat=%h c=%b l=%b m=%b d=%0d t=%b",
                         k, busy2, lat2, cdiv2, ldiv2, mask2, dcyc2, to2, any2,
                         {m_act[1], m_act[0]}, {m_lat[1], m_lat[0]}, m_cdiv, m_ldiv, m_mask, m_dcyc, m_to);
            end else n_pass++;
            arm2   = ($urandom_range(0, 3) != 0);
            start2 = 2'($urandom);
            done2  = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00;
            ctrl2[3:0] = 4'($urandom);
            ctrl2[7:4] = ($urandom_range(0, 29) == 0) ? (ctrl2[3:0] ^ 4'(1 << $urandom_range(0, 3))) : ctrl2[3:0];
            clear  = ($urandom_range(0, 59) == 0);
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_equal_timing();
        test_latency_skew();
        test_ctrl_divergence();
        test_timeout();
        test_edge_cases();
        test_channel_scaling();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
